// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters with a per-port response register.
// Tie-breaking is round-robin unless ALU_ARB_FIXED_PRIO_EN is defined (port 0 always wins).
module alu_arbiter #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned CTRL_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [WIDTH-1:0]  req0_r1,
    input  logic [WIDTH-1:0]  req0_r2,
    input  logic [WIDTH-1:0]  req1_r1,
    input  logic [WIDTH-1:0]  req1_r2,
    input  logic [CTRL_W-1:0] req0_control,
    input  logic [CTRL_W-1:0] req1_control,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [WIDTH-1:0]  rsp0_result,
    output logic [WIDTH-1:0]  rsp1_result,
    output logic              rsp0_zero,
    output logic              rsp1_zero,
    output logic [WIDTH-1:0]  alu_r1,
    output logic [WIDTH-1:0]  alu_r2,
    output logic [CTRL_W-1:0] alu_control,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              alu_zero
);

    localparam logic [CTRL_W-1:0] CTRL_BEQ = CTRL_W'(4'b1000);
    localparam logic [CTRL_W-1:0] CTRL_BNE = CTRL_W'(4'b1001);

    logic [1:0]       eligible;
    logic [1:0]       grant;
    logic [WIDTH-1:0] capt_result;

    logic [1:0]       rsp_valid_q,   rsp_valid_d;
    logic [WIDTH-1:0] rsp0_result_q, rsp0_result_d;
    logic [WIDTH-1:0] rsp1_result_q, rsp1_result_d;
    logic             rsp0_zero_q,   rsp0_zero_d;
    logic             rsp1_zero_q,   rsp1_zero_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic             last_grant_q,  last_grant_d;
`endif

    // A port may issue when its response slot is empty or being drained this cycle.
    assign eligible = req_valid & (~rsp_valid_q | rsp_ready);

    always_comb begin
        grant = '0;
        if (!reset) begin
            if (eligible == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                grant = 2'b01;
`else
                grant = last_grant_q ? 2'b01 : 2'b10;
`endif
            end else begin
                grant = eligible;
            end
        end
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    // Pointer only moves on a genuine tie; lone grants leave it untouched.
    always_comb begin
        last_grant_d = last_grant_q;
        if (eligible == 2'b11 && !reset)
            last_grant_d = grant[1];
    end
`endif

    always_comb begin
        if (grant[1]) begin
            alu_r1      = req1_r1;
            alu_r2      = req1_r2;
            alu_control = req1_control;
        end else begin
            alu_r1      = req0_r1;
            alu_r2      = req0_r2;
            alu_control = req0_control;
        end
    end

    // The ALU leaves result stale for branch compares, so capture zero instead.
    assign capt_result = (alu_control == CTRL_BEQ || alu_control == CTRL_BNE) ? '0 : alu_result;

    always_comb begin
        rsp_valid_d   = rsp_valid_q;
        rsp0_result_d = rsp0_result_q;
        rsp1_result_d = rsp1_result_q;
        rsp0_zero_d   = rsp0_zero_q;
        rsp1_zero_d   = rsp1_zero_q;
        if (grant[0]) begin
            rsp_valid_d[0] = 1'b1;
            rsp0_result_d  = capt_result;
            rsp0_zero_d    = alu_zero;
        end else if (rsp_ready[0]) begin
            rsp_valid_d[0] = 1'b0;
        end
        if (grant[1]) begin
            rsp_valid_d[1] = 1'b1;
            rsp1_result_d  = capt_result;
            rsp1_zero_d    = alu_zero;
        end else if (rsp_ready[1]) begin
            rsp_valid_d[1] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q   <= '0;
            rsp0_result_q <= '0;
            rsp1_result_q <= '0;
            rsp0_zero_q   <= 1'b0;
            rsp1_zero_q   <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant_q  <= 1'b1;
`endif
        end else begin
            rsp_valid_q   <= rsp_valid_d;
            rsp0_result_q <= rsp0_result_d;
            rsp1_result_q <= rsp1_result_d;
            rsp0_zero_q   <= rsp0_zero_d;
            rsp1_zero_q   <= rsp1_zero_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant_q  <= last_grant_d;
`endif
        end
    end

    assign req_ready   = grant;
    assign rsp_valid   = rsp_valid_q;
    assign rsp0_result = rsp0_result_q;
    assign rsp1_result = rsp1_result_q;
    assign rsp0_zero   = rsp0_zero_q;
    assign rsp1_zero   = rsp1_zero_q;

endmodule
